// File: rtl/id_ex_stage.sv
// id_ex_stage: instruction decode with WB bypass, load-use hazard detection and the ID/EX pipeline register
module id_ex_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instr_in,
    input  logic [31:0]       pc4_in,
    input  logic              valid_in,
    output logic [4:0]        reg1addr,
    output logic [4:0]        reg2addr,
    input  logic [DATA_W-1:0] reg1content,
    input  logic [DATA_W-1:0] reg2content,
    input  logic              wb_regWrite,
    input  logic [4:0]        wb_writeRegister,
    input  logic [DATA_W-1:0] wb_writeData,
    input  logic              flush,
    output logic              stall,
    output logic              ex_valid,
    output logic [31:0]       ex_pc4,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_dest,
    output logic              ex_regWrite,
    output logic              ex_memRead,
    output logic              ex_memWrite,
    output logic              ex_memToReg,
    output logic              ex_aluSrc,
    output logic              ex_branch,
    output logic [1:0]        ex_aluOp,
    output logic [15:0]       bubble_cnt
);
    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;

    logic [5:0]        opcode;
    logic [4:0]        rs, rt, rd;
    logic              is_r, is_lw, is_sw, is_beq, is_addi, uses_rt;
    logic              reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch;
    logic [1:0]        alu_op;
    logic [4:0]        dest;
    logic [DATA_W-1:0] rs_val, rt_val, imm;
    logic              bubble;

    assign opcode   = instr_in[31:26];
    assign rs       = instr_in[25:21];
    assign rt       = instr_in[20:16];
    assign rd       = instr_in[15:11];
    assign reg1addr = rs;
    assign reg2addr = rt;

    // Decode the opcode into EX control; unknown opcodes fall through as all-zero control
    always_comb begin
        is_r       = opcode == OP_R;
        is_lw      = opcode == OP_LW;
        is_sw      = opcode == OP_SW;
        is_beq     = opcode == OP_BEQ;
        is_addi    = opcode == OP_ADDI;
        uses_rt    = is_r || is_sw || is_beq;
        reg_write  = is_r || is_lw || is_addi;
        mem_read   = is_lw;
        mem_write  = is_sw;
        mem_to_reg = is_lw;
        alu_src    = is_lw || is_sw || is_addi;
        branch     = is_beq;
        alu_op     = is_r ? 2'b10 : is_beq ? 2'b01 : 2'b00;
        dest       = is_r ? rd : (is_lw || is_addi) ? rt : 5'd0;
    end

    // $0 always reads as zero; otherwise the WB write wins over the stale register-file read
    assign rs_val = (rs == 5'd0) ? '0 : (wb_regWrite && wb_writeRegister == rs) ? wb_writeData : reg1content;
    assign rt_val = (rt == 5'd0) ? '0 : (wb_regWrite && wb_writeRegister == rt) ? wb_writeData : reg2content;
    assign imm    = {{(DATA_W-16){instr_in[15]}}, instr_in[15:0]};

    // A load in EX whose destination feeds this instruction must wait one cycle; a flush kills the hazard
    assign stall  = !reset && !flush && valid_in && ex_valid && ex_memRead && ex_dest != 5'd0 &&
                    (ex_dest == rs || (uses_rt && ex_dest == rt));
    assign bubble = flush || stall || !valid_in;

    // ID/EX register: data always advances, control is zeroed whenever a bubble is inserted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid    <= 1'b0;
            ex_pc4      <= '0;
            ex_rs_data  <= '0;
            ex_rt_data  <= '0;
            ex_imm      <= '0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_dest     <= '0;
            ex_regWrite <= 1'b0;
            ex_memRead  <= 1'b0;
            ex_memWrite <= 1'b0;
            ex_memToReg <= 1'b0;
            ex_aluSrc   <= 1'b0;
            ex_branch   <= 1'b0;
            ex_aluOp    <= '0;
            bubble_cnt  <= '0;
        end else begin
            ex_valid    <= !bubble;
            ex_pc4      <= pc4_in;
            ex_rs_data  <= rs_val;
            ex_rt_data  <= rt_val;
            ex_imm      <= imm;
            ex_rs       <= rs;
            ex_rt       <= rt;
            ex_dest     <= dest;
            ex_regWrite <= !bubble && reg_write;
            ex_memRead  <= !bubble && mem_read;
            ex_memWrite <= !bubble && mem_write;
            ex_memToReg <= !bubble && mem_to_reg;
            ex_aluSrc   <= !bubble && alu_src;
            ex_branch   <= !bubble && branch;
            ex_aluOp    <= bubble ? 2'b00 : alu_op;
            if (stall && bubble_cnt != 16'hFFFF)
                bubble_cnt <= bubble_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vectors with a scoreboard queue checked by an independent monitor
module tb_id_ex_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instr_in = '0, pc4_in = '0;
    logic        valid_in = 1'b0;
    logic [4:0]  reg1addr, reg2addr;
    logic [31:0] reg1content = '0, reg2content = '0;
    logic        wb_regWrite = 1'b0;
    logic [4:0]  wb_writeRegister = '0;
    logic [31:0] wb_writeData = '0;
    logic        flush = 1'b0;
    logic        stall;
    logic        ex_valid;
    logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_dest;
    logic        ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg, ex_aluSrc, ex_branch;
    logic [1:0]  ex_aluOp;
    logic [15:0] bubble_cnt;
    logic [7:0]  ctrl;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        bub;
        logic        v;
        logic [31:0] pc4, rsd, rtd, imm;
        logic [4:0]  rs, rt, dest;
        logic [7:0]  ctrl;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];

    localparam logic [31:0] ADDI  = 32'h20080005;
    localparam logic [31:0] LW    = 32'h8D090000;
    localparam logic [31:0] ADD   = 32'h012B5020;
    localparam logic [31:0] SW11  = 32'hAD0B0004;
    localparam logic [31:0] BEQ   = 32'h1008FFFF;
    localparam logic [31:0] NOP   = 32'hFC200000;
    localparam logic [31:0] SW9   = 32'hAD090004;
    localparam logic [31:0] ADDI9 = 32'h21090001;

    id_ex_stage #(.DATA_W(32)) dut (
        .clk(clk), .reset(reset), .instr_in(instr_in), .pc4_in(pc4_in), .valid_in(valid_in),
        .reg1addr(reg1addr), .reg2addr(reg2addr), .reg1content(reg1content), .reg2content(reg2content),
        .wb_regWrite(wb_regWrite), .wb_writeRegister(wb_writeRegister), .wb_writeData(wb_writeData),
        .flush(flush), .stall(stall), .ex_valid(ex_valid), .ex_pc4(ex_pc4),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest),
        .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
        .ex_memToReg(ex_memToReg), .ex_aluSrc(ex_aluSrc), .ex_branch(ex_branch),
        .ex_aluOp(ex_aluOp), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    assign ctrl = {ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg, ex_aluSrc, ex_branch, ex_aluOp};

    function automatic exp_t mk(logic v, logic [31:0] pc4, rsd, rtd, imm, logic [4:0] rs, rt, dest,
                                logic [7:0] c, logic [15:0] cnt);
        return '{bub: 1'b0, v: v, pc4: pc4, rsd: rsd, rtd: rtd, imm: imm, rs: rs, rt: rt, dest: dest, ctrl: c, cnt: cnt};
    endfunction

    function automatic exp_t bub(logic [15:0] cnt);
        exp_t e;
        e = '0;
        e.bub = 1'b1;
        e.cnt = cnt;
        return e;
    endfunction

    task automatic step(input logic [31:0] instr, pc4, r1, r2, input logic v, fl, wbw,
                        input logic [4:0] wbr, input logic [31:0] wbd, input logic st, input exp_t e);
        @(negedge clk);
        instr_in = instr; pc4_in = pc4; reg1content = r1; reg2content = r2; valid_in = v; flush = fl;
        wb_regWrite = wbw; wb_writeRegister = wbr; wb_writeData = wbd;
        #1;
        checks++;
        if (stall !== st) begin
            errors++;
            $display("FAIL stall pc4=%h: got %b want %b", pc4, stall, st);
        end
        sb.push_back(e);
    endtask

    task automatic check_cleared(input string name);
        checks++;
        if ({stall, ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_dest, ctrl, bubble_cnt} !== '0) begin
            errors++;
            $display("FAIL %s: got stall=%b valid=%b pc4=%h rs=%h rt=%h imm=%h ctrl=%h cnt=%h want all zero",
                     name, stall, ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ctrl, bubble_cnt);
        end
    endtask

    // Monitor: after every rising edge, compare the EX register against the oldest expectation
    initial begin
        exp_t e;
        logic [167:0] act, want;
        int n = 0;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n++;
                checks++;
                if (e.bub) begin
                    act  = {143'd0, ex_valid, ctrl, bubble_cnt};
                    want = {143'd0, 1'b0, 8'h00, e.cnt};
                end else begin
                    act  = {ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt,
                            e.ctrl[7] ? ex_dest : 5'd0, ctrl, bubble_cnt};
                    want = {e.v, e.pc4, e.rsd, e.rtd, e.imm, e.rs, e.rt,
                            e.ctrl[7] ? e.dest : 5'd0, e.ctrl, e.cnt};
                end
                if (act !== want) begin
                    errors++;
                    $display("FAIL ex_regs #%0d: got %h want %h", n, act, want);
                end
            end
        end
    end

    initial begin
        #1 reset = 1'b1;
        #2 check_cleared("reset_state");
        @(negedge clk) reset = 1'b0;
        step(ADDI,  32'h104, 32'h77,   32'h55, 1, 0, 0, 5'd0,  32'h0,        0, mk(1, 32'h104, 32'h0,   32'h55,   32'h5,        5'd0, 5'd8,  5'd8,  8'h88, 16'd0));
        step(LW,    32'h108, 32'h5,    32'hAA, 1, 0, 0, 5'd0,  32'h0,        0, mk(1, 32'h108, 32'h5,   32'hAA,   32'h0,        5'd8, 5'd9,  5'd9,  8'hD8, 16'd0));
        step(ADD,   32'h10C, 32'h100,  32'h84, 1, 0, 1, 5'd9,  32'h900,      1, bub(16'd1));
        step(ADD,   32'h10C, 32'h100,  32'h84, 1, 0, 1, 5'd9,  32'h900,      0, mk(1, 32'h10C, 32'h900, 32'h84,   32'h5020,     5'd9, 5'd11, 5'd10, 8'h82, 16'd1));
        step(SW11,  32'h110, 32'h5,    32'h84, 1, 0, 1, 5'd11, 32'h1234,     0, mk(1, 32'h110, 32'h5,   32'h1234, 32'h4,        5'd8, 5'd11, 5'd0,  8'h28, 16'd1));
        step(BEQ,   32'h114, 32'hDEAD, 32'h33, 1, 0, 1, 5'd0,  32'hFFFFFFFF, 0, mk(1, 32'h114, 32'h0,   32'h33,   32'hFFFFFFFF, 5'd0, 5'd8,  5'd0,  8'h05, 16'd1));
        step(NOP,   32'h118, 32'h11,   32'h22, 1, 0, 0, 5'd0,  32'h0,        0, mk(1, 32'h118, 32'h11,  32'h0,    32'h0,        5'd1, 5'd0,  5'd0,  8'h00, 16'd1));
        step(ADDI,  32'h11C, 32'h0,    32'h0,  0, 0, 0, 5'd0,  32'h0,        0, bub(16'd1));
        step(LW,    32'h120, 32'h5,    32'hAA, 1, 0, 0, 5'd0,  32'h0,        0, mk(1, 32'h120, 32'h5,   32'hAA,   32'h0,        5'd8, 5'd9,  5'd9,  8'hD8, 16'd1));
        step(ADD,   32'h124, 32'h100,  32'h84, 1, 1, 0, 5'd0,  32'h0,        0, bub(16'd1));
        step(LW,    32'h128, 32'h5,    32'hAA, 1, 0, 0, 5'd0,  32'h0,        0, mk(1, 32'h128, 32'h5,   32'hAA,   32'h0,        5'd8, 5'd9,  5'd9,  8'hD8, 16'd1));
        step(SW9,   32'h12C, 32'h5,    32'hAA, 1, 0, 0, 5'd0,  32'h0,        1, bub(16'd2));
        step(SW9,   32'h12C, 32'h5,    32'h99, 1, 0, 0, 5'd0,  32'h0,        0, mk(1, 32'h12C, 32'h5,   32'h99,   32'h4,        5'd8, 5'd9,  5'd0,  8'h28, 16'd2));
        step(LW,    32'h130, 32'h5,    32'hAA, 1, 0, 0, 5'd0,  32'h0,        0, mk(1, 32'h130, 32'h5,   32'hAA,   32'h0,        5'd8, 5'd9,  5'd9,  8'hD8, 16'd2));
        step(ADDI9, 32'h134, 32'h5,    32'hAA, 1, 0, 0, 5'd0,  32'h0,        0, mk(1, 32'h134, 32'h5,   32'hAA,   32'h1,        5'd8, 5'd9,  5'd9,  8'h88, 16'd2));
        step(LW,    32'h138, 32'h5,    32'hAA, 1, 0, 0, 5'd0,  32'h0,        0, mk(1, 32'h138, 32'h5,   32'hAA,   32'h0,        5'd8, 5'd9,  5'd9,  8'hD8, 16'd2));
        step(ADD,   32'h13C, 32'h100,  32'h84, 0, 0, 0, 5'd0,  32'h0,        0, bub(16'd2));
        @(negedge clk);
        force dut.bubble_cnt = 16'hFFFE;
        #1 release dut.bubble_cnt;
        step(LW,    32'h140, 32'h5,    32'hAA, 1, 0, 0, 5'd0,  32'h0,        0, mk(1, 32'h140, 32'h5,   32'hAA,   32'h0,        5'd8, 5'd9,  5'd9,  8'hD8, 16'hFFFE));
        step(ADD,   32'h144, 32'h100,  32'h84, 1, 0, 0, 5'd0,  32'h0,        1, bub(16'hFFFF));
        step(ADD,   32'h144, 32'h100,  32'h84, 1, 0, 0, 5'd0,  32'h0,        0, mk(1, 32'h144, 32'h100, 32'h84,   32'h5020,     5'd9, 5'd11, 5'd10, 8'h82, 16'hFFFF));
        step(LW,    32'h148, 32'h5,    32'hAA, 1, 0, 0, 5'd0,  32'h0,        0, mk(1, 32'h148, 32'h5,   32'hAA,   32'h0,        5'd8, 5'd9,  5'd9,  8'hD8, 16'hFFFF));
        step(ADD,   32'h14C, 32'h100,  32'h84, 1, 0, 0, 5'd0,  32'h0,        1, bub(16'hFFFF));
        step(LW,    32'h150, 32'h5,    32'hAA, 1, 0, 0, 5'd0,  32'h0,        0, mk(1, 32'h150, 32'h5,   32'hAA,   32'h0,        5'd8, 5'd9,  5'd9,  8'hD8, 16'hFFFF));
        @(negedge clk);
        instr_in = ADD; pc4_in = 32'h154; reg1content = 32'h100; reg2content = 32'h84; valid_in = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_stall: got %b want 1", stall);
        end
        #1 reset = 1'b1;
        #1 check_cleared("async_reset");
        @(negedge clk) reset = 1'b0;
        step(ADD,   32'h158, 32'h100,  32'h84, 1, 0, 0, 5'd0,  32'h0,        0, mk(1, 32'h158, 32'h100, 32'h84,   32'h5020,     5'd9, 5'd11, 5'd10, 8'h82, 16'd0));
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
